// File: rtl/cordic_iter_core_pkg.sv
// Shared definitions for the iterative CORDIC core: FSM state encoding and the pi/2 constant.
// Used by cordic_iter_core (quadrant pre-rotation under CORDIC_QUAD_EXT_EN).
package cordic_iter_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ITER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // pi/2 with 61 fractional bits (pi * 2^60); rescaled to the working format with rounding.
    localparam logic [63:0] PI_HALF_Q61 = 64'h3243F6A8885A308D;

    function automatic logic [63:0] pi_half_q(input int frac_bits);
        int sh;
        sh = 61 - frac_bits;
        if (sh <= 0) begin
            return PI_HALF_Q61;
        end
        return (PI_HALF_Q61 + (64'd1 << (sh - 1))) >> sh;
    endfunction

endpackage

// File: rtl/cordic_iter_core_stage.sv
// Combinational single CORDIC micro-rotation in rotation mode (drives z toward zero).
// Arithmetic shifts, two's complement wrap-around, no rounding or saturation.
module cordic_stage #(
    parameter int BIT_WIDTH  = 32,
    parameter int DEPTH_BITS = 4
) (
    input  logic signed [BIT_WIDTH-1:0]  x,
    input  logic signed [BIT_WIDTH-1:0]  y,
    input  logic signed [BIT_WIDTH-1:0]  z,
    input  logic        [DEPTH_BITS-1:0] shift,
    input  logic signed [BIT_WIDTH-1:0]  atan,
    output logic signed [BIT_WIDTH-1:0]  x_next,
    output logic signed [BIT_WIDTH-1:0]  y_next,
    output logic signed [BIT_WIDTH-1:0]  z_next
);

    logic signed [BIT_WIDTH-1:0] x_sh;
    logic signed [BIT_WIDTH-1:0] y_sh;

    assign x_sh = x >>> shift;
    assign y_sh = y >>> shift;

    // d = +1 when z >= 0, i.e. sign bit clear
    always_comb begin
        if (!z[BIT_WIDTH-1]) begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - atan;
        end else begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + atan;
        end
    end

endmodule

// File: rtl/cordic_iter_core.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, atan LUT read with 1-cycle latency.
// Optional CORDIC_QUAD_EXT_EN: quadrant pre-rotation in FETCH extends the angle range to +/-pi.
module cordic_iter_core
    import cordic_iter_core_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int FRAC_BITS  = 29,
    parameter int ITERATIONS = 16,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIT_WIDTH-1:0]  in_x,
    input  logic [BIT_WIDTH-1:0]  in_y,
    input  logic [BIT_WIDTH-1:0]  in_z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIT_WIDTH-1:0]  out_x,
    output logic [BIT_WIDTH-1:0]  out_y,
    output logic [BIT_WIDTH-1:0]  out_z,
    output logic [DEPTH_BITS-1:0] rom_addr,
    input  logic [BIT_WIDTH-1:0]  rom_data
);

    localparam logic [DEPTH_BITS-1:0] LAST_ITER = DEPTH_BITS'(ITERATIONS - 1);

    if (FRAC_BITS >= BIT_WIDTH || ITERATIONS < 1 || ITERATIONS > (2 ** DEPTH_BITS)) begin : g_bad_cfg
        $error("cordic_iter_core: inconsistent FRAC_BITS/ITERATIONS/DEPTH_BITS");
    end

`ifdef CORDIC_QUAD_EXT_EN
    localparam logic signed [BIT_WIDTH-1:0] PI_HALF = BIT_WIDTH'(pi_half_q(FRAC_BITS));
`endif

    state_t state_reg, state_next;
    logic [DEPTH_BITS-1:0] iter_reg, iter_next;
    logic [DEPTH_BITS-1:0] addr_reg, addr_next;

    logic signed [BIT_WIDTH-1:0] x_reg, y_reg, z_reg;
    logic signed [BIT_WIDTH-1:0] x_next, y_next, z_next;
    logic signed [BIT_WIDTH-1:0] res_x_reg, res_y_reg, res_z_reg;
    logic signed [BIT_WIDTH-1:0] res_x_next, res_y_next, res_z_next;
    logic signed [BIT_WIDTH-1:0] stage_x, stage_y, stage_z;

    cordic_stage #(
        .BIT_WIDTH (BIT_WIDTH),
        .DEPTH_BITS(DEPTH_BITS)
    ) u_stage (
        .x     (x_reg),
        .y     (y_reg),
        .z     (z_reg),
        .shift (iter_reg),
        .atan  ($signed(rom_data)),
        .x_next(stage_x),
        .y_next(stage_y),
        .z_next(stage_z)
    );

    always_comb begin
        state_next = state_reg;
        iter_next  = iter_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        z_next     = z_reg;
        res_x_next = res_x_reg;
        res_y_next = res_y_reg;
        res_z_next = res_z_reg;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    x_next     = $signed(in_x);
                    y_next     = $signed(in_y);
                    z_next     = $signed(in_z);
                    iter_next  = '0;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
`ifdef CORDIC_QUAD_EXT_EN
                if (z_reg > PI_HALF) begin
                    x_next = -y_reg;
                    y_next = x_reg;
                    z_next = z_reg - PI_HALF;
                end else if (z_reg < -PI_HALF) begin
                    x_next = y_reg;
                    y_next = -x_reg;
                    z_next = z_reg + PI_HALF;
                end
`endif
                iter_next  = '0;
                state_next = ST_ITER;
            end
            ST_ITER: begin
                x_next = stage_x;
                y_next = stage_y;
                z_next = stage_z;
                if (iter_reg == LAST_ITER) begin
                    res_x_next = stage_x;
                    res_y_next = stage_y;
                    res_z_next = stage_z;
                    iter_next  = '0;
                    state_next = ST_DONE;
                end else begin
                    iter_next = iter_reg + DEPTH_BITS'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Address is one step ahead of the iteration so the registered LUT data lines up.
        if (state_next == ST_ITER && iter_next != LAST_ITER) begin
            addr_next = iter_next + DEPTH_BITS'(1);
        end else begin
            addr_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            iter_reg  <= '0;
            addr_reg  <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            res_x_reg <= '0;
            res_y_reg <= '0;
            res_z_reg <= '0;
        end else begin
            state_reg <= state_next;
            iter_reg  <= iter_next;
            addr_reg  <= addr_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            z_reg     <= z_next;
            res_x_reg <= res_x_next;
            res_y_reg <= res_y_next;
            res_z_reg <= res_z_next;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign out_x     = res_x_reg;
    assign out_y     = res_y_reg;
    assign out_z     = res_z_reg;
    assign rom_addr  = addr_reg;

endmodule

// File: tb/tb_cordic_iter_core.sv
// Directed bench for cordic_iter_core with a registered atan(2^-i) LUT model.
// Quadrant-extension vectors run only when CORDIC_QUAD_EXT_EN is defined.
module tb_cordic_iter_core;

    localparam int  W   = 32;
    localparam int  F   = 29;
    localparam int  N   = 16;
    localparam int  DB  = 4;
    localparam real TOL = 1.0 / 16384.0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x, in_y, in_z;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_x, out_y, out_z;
    logic [DB-1:0] rom_addr;
    logic [W-1:0]  rom_data = '0;
    logic [W-1:0]  lut_mem [0:N-1];

    int checks = 0;
    int errors = 0;
    int lat;
    int gap;
    bit addr_ok;

    cordic_iter_core #(
        .BIT_WIDTH (W),
        .FRAC_BITS (F),
        .ITERATIONS(N),
        .DEPTH_BITS(DB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_z     (in_z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_z    (out_z),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= lut_mem[rom_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] to_q(input real r);
        return $rtoi(r * (2.0 ** F));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [W-1:0] obs, input real exp);
        real o;
        o = $itor($signed(obs)) / (2.0 ** F);
        checks++;
        assert ((o - exp) <= TOL && (exp - o) <= TOL) else begin
            errors++;
            $error("FAIL %s: observed %f expected %f", tag, o, exp);
        end
    endtask

    // Accept one vector from IDLE and wait (bounded) for out_valid; logs the LUT address sequence.
    task automatic start_and_wait(input real x, input real y, input real z,
                                  output int cycles, output bit seq_ok);
        logic [DB-1:0] exp_addr;
        in_x     = to_q(x);
        in_y     = to_q(y);
        in_z     = to_q(z);
        in_valid = 1'b1;
        check_eq("in_ready_before_accept", in_ready, 1);
        tick();
        in_valid = 1'b0;
        cycles   = 0;
        seq_ok   = 1'b1;
        while (!out_valid && cycles < 60) begin
            exp_addr = (cycles < N) ? DB'(cycles) : '0;
            if (cycles <= N && rom_addr !== exp_addr) seq_ok = 1'b0;
            tick();
            cycles++;
        end
    endtask

    initial begin
        real p;
        p = 1.0;
        for (int i = 0; i < N; i++) begin
            lut_mem[i] = $rtoi($atan(p) * (2.0 ** F) + 0.5);
            p = p / 2.0;
        end

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_x", out_x, 0);
        check_eq("rst_rom_addr", rom_addr, 0);
        rst_n = 1'b1;
        tick();

        // Unit vector, zero angle: gain only
        start_and_wait(1.0, 0.0, 0.0, lat, addr_ok);
        $display("txn gain: latency=%0d", lat);
        check_eq("gain_latency", lat, 17);
        check_eq("gain_addr_seq", addr_ok, 1);
        check_near("gain_out_x", out_x, 1.646760);
        check_near("gain_out_y", out_y, 0.0);
        check_near("gain_out_z", out_z, 0.0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("gain_idle_in_ready", in_ready, 1);
        check_eq("gain_idle_out_valid", out_valid, 0);

        // Asynchronous reset in the middle of ITER
        in_x     = to_q(0.5);
        in_y     = to_q(0.25);
        in_z     = to_q(0.3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #2;
        $display("txn reset mid-iter");
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_out_x", out_x, 0);
        check_eq("midrst_out_y", out_y, 0);
        check_eq("midrst_out_z", out_z, 0);
        check_eq("midrst_rom_addr", rom_addr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) tick();
        check_eq("midrst_no_partial", out_valid, 0);

        // 45 degrees with 1/K prescale
        start_and_wait(0.607253, 0.0, 0.785398, lat, addr_ok);
        $display("txn 45deg: latency=%0d", lat);
        check_eq("r45_latency", lat, 17);
        check_eq("r45_addr_seq", addr_ok, 1);
        check_near("r45_out_x", out_x, 0.707107);
        check_near("r45_out_y", out_y, 0.707107);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("r45_idle_in_ready", in_ready, 1);

        // Backpressure: DONE held 10 cycles while in_valid toggles new data
        start_and_wait(0.607253, 0.0, -0.785398, lat, addr_ok);
        $display("txn backpressure: latency=%0d", lat);
        check_eq("bp_latency", lat, 17);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_x     = to_q(1.0);
            in_y     = to_q(0.0);
            in_z     = to_q(0.5);
            tick();
            check_eq("bp_out_valid", out_valid, 1);
            check_eq("bp_in_ready", in_ready, 0);
            check_near("bp_out_x", out_x, 0.707107);
            check_near("bp_out_y", out_y, -0.707107);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_release_in_ready", in_ready, 1);
        check_eq("bp_release_out_valid", out_valid, 0);
        tick();
        check_eq("bp_stays_idle", in_ready, 1);

        // Back-to-back with in_valid held high and out_ready high
        in_x      = to_q(1.0);
        in_y      = to_q(0.0);
        in_z      = to_q(0.0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        lat = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        $display("txn b2b first: latency=%0d", lat);
        check_eq("b2b_first_latency", lat, 17);
        check_near("b2b_first_out_x", out_x, 1.646760);
        check_near("b2b_first_out_y", out_y, 0.0);
        in_x = to_q(0.607253);
        in_z = to_q(0.785398);
        gap  = 0;
        do begin
            tick();
            gap++;
        end while (!out_valid && gap < 60);
        in_valid = 1'b0;
        $display("txn b2b second: gap=%0d", gap);
        check_eq("b2b_gap", gap, 19);
        check_near("b2b_second_out_x", out_x, 0.707107);
        check_near("b2b_second_out_y", out_y, 0.707107);
        tick();
        out_ready = 1'b0;
        check_eq("b2b_idle_in_ready", in_ready, 1);

`ifdef CORDIC_QUAD_EXT_EN
        start_and_wait(0.607253, 0.0, 2.5, lat, addr_ok);
        $display("txn quad +2.5: latency=%0d", lat);
        check_eq("quadp_latency", lat, 17);
        check_near("quadp_out_x", out_x, -0.801144);
        check_near("quadp_out_y", out_y, 0.598472);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        start_and_wait(0.607253, 0.0, -2.5, lat, addr_ok);
        $display("txn quad -2.5: latency=%0d", lat);
        check_eq("quadn_latency", lat, 17);
        check_near("quadn_out_x", out_x, -0.801144);
        check_near("quadn_out_y", out_y, -0.598472);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
